// File: rtl/perceptron_layer_pkg.sv
// Shared Q-format widths, Heaviside levels, FSM encoding and saturation helper
// for the trainable perceptron layer.
package perceptron_layer_pkg;

  localparam int ARG_W    = 8;   // Q1.7 input
  localparam int WGT_W    = 16;  // Q8.8 weight / bias / error
  localparam int ACC_W    = 32;  // Q9.15 accumulator
  localparam int FRAC     = 8;
  localparam int ARG_FRAC = 7;

  localparam logic [ARG_W-1:0] HEAVI_HI = 8'hFF;
  localparam logic [ARG_W-1:0] HEAVI_LO = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FWD  = 3'd1,
    ST_RES  = 3'd2,
    ST_ERR  = 3'd3,
    ST_BWD  = 3'd4,
    ST_FBK  = 3'd5
  } state_e;

  function automatic logic [WGT_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
    if (v > 32'sd32767) begin
      return 16'h7FFF;
    end else if (v < -32'sd32768) begin
      return 16'h8000;
    end else begin
      return v[WGT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/perceptron_layer_if.sv
// Stream channels of the perceptron layer: forward arg/res and learning err/fbk,
// each a stb/rdy handshake, plus the learning enable sampled with the result.
interface perceptron_layer_if
  import perceptron_layer_pkg::*;
#(
  parameter int ARGD = 2,
  parameter int OUTD = 2
);

  logic                    en;
  logic                    arg_stb;
  logic [ARG_W*ARGD-1:0]   arg_dat;
  logic                    arg_rdy;
  logic                    res_stb;
  logic [ARG_W*OUTD-1:0]   res_dat;
  logic                    res_rdy;
  logic                    err_stb;
  logic [WGT_W*OUTD-1:0]   err_dat;
  logic                    err_rdy;
  logic                    fbk_stb;
  logic [WGT_W*ARGD-1:0]   fbk_dat;
  logic                    fbk_rdy;

  modport master (
    output en, arg_stb, arg_dat, res_rdy, err_stb, err_dat, fbk_rdy,
    input  arg_rdy, res_stb, res_dat, err_rdy, fbk_stb, fbk_dat
  );

  modport slave (
    input  en, arg_stb, arg_dat, res_rdy, err_stb, err_dat, fbk_rdy,
    output arg_rdy, res_stb, res_dat, err_rdy, fbk_stb, fbk_dat
  );

endinterface

// File: rtl/perceptron_layer_weights.sv
// Weight/bias register bank: one combinational read port, one write port,
// synchronous clear on reset. Word j*(ARGD+1)+k holds w[j][k]; k==ARGD is the bias.
module perceptron_layer_weights
  import perceptron_layer_pkg::*;
#(
  parameter int DEPTH = 6,
  parameter int AW    = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WGT_W-1:0] rd_data_o,
  input  logic             we_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WGT_W-1:0] wr_data_i
);

  logic [WGT_W-1:0] mem_q [DEPTH];

  // Storage update: clear on reset, otherwise single-word write
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int n = 0; n < DEPTH; n++) begin
        mem_q[n] <= '0;
      end
    end else if (we_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/perceptron_layer.sv
// Trainable single-layer perceptron: one time-multiplexed MAC walks every
// (neuron, input/bias) word for the forward pass and again for the learning pass.
module perceptron_layer
  import perceptron_layer_pkg::*;
#(
  parameter int ARGD = 2,
  parameter int OUTD = 2,
  parameter int RATE = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  perceptron_layer_if.slave bus
);

  localparam int N  = OUTD * (ARGD + 1);
  localparam int AW = $clog2(N + 1);
  localparam int KW = $clog2(ARGD + 1);
  localparam int JW = $clog2(OUTD + 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(N - 1);
  localparam logic [AW-1:0] ADDR_END  = AW'(N);
  localparam logic [KW-1:0] K_BIAS    = KW'(ARGD);

  state_e state_q, state_d;

  logic [AW-1:0]           addr_q;
  logic [KW-1:0]           k_q;
  logic [JW-1:0]           j_q;
  logic [ARG_W*ARGD-1:0]   arg_q;
  logic [WGT_W*OUTD-1:0]   err_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [ACC_W*ARGD-1:0]   fbk_q;
  logic [ARG_W*OUTD-1:0]   res_q;

  logic                    is_bias_s;
  logic                    we_s;
  logic [KW-1:0]           k_arg_s;
  logic [AW-1:0]           rd_addr_s;
  logic [WGT_W-1:0]        rd_data_s;
  logic [WGT_W-1:0]        wr_data_s;
  logic [ARG_W-1:0]        arg_sel_s;
  logic [WGT_W-1:0]        err_sel_s;
  logic signed [ACC_W-1:0] arg_x_s, err_x_s, wgt_x_s;
  logic signed [ACC_W-1:0] fwd_term_s, sum_s, fbk_term_s, fbk_sum_s, upd_s;
  logic [AW-1:0]           addr_nx_s;
  logic [KW-1:0]           k_nx_s;
  logic [JW-1:0]           j_nx_s;

  perceptron_layer_weights #(
    .DEPTH (N),
    .AW    (AW)
  ) u_wgt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .rd_addr_i (rd_addr_s),
    .rd_data_o (rd_data_s),
    .we_i      (we_s),
    .wr_addr_i (addr_q),
    .wr_data_i (wr_data_s)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.arg_stb) state_d = ST_FWD; else state_d = ST_IDLE;
      ST_FWD:  if (addr_q == ADDR_END) state_d = ST_RES; else state_d = ST_FWD;
      ST_RES: begin
        if (bus.res_rdy) state_d = bus.en ? ST_ERR : ST_IDLE;
        else state_d = ST_RES;
      end
      ST_ERR:  if (bus.err_stb) state_d = ST_BWD; else state_d = ST_ERR;
      ST_BWD:  if (addr_q == ADDR_LAST) state_d = ST_FBK; else state_d = ST_BWD;
      ST_FBK:  if (bus.fbk_rdy) state_d = ST_IDLE; else state_d = ST_FBK;
      default: state_d = ST_IDLE;
    endcase
  end

  // MAC operands, forward/learning arithmetic and index stepping
  always_comb begin
    is_bias_s  = (k_q == K_BIAS);
    k_arg_s    = is_bias_s ? '0 : k_q;
    rd_addr_s  = (addr_q == ADDR_END) ? '0 : addr_q;
    arg_sel_s  = arg_q[ARG_W*k_arg_s +: ARG_W];
    err_sel_s  = err_q[WGT_W*j_q +: WGT_W];
    arg_x_s    = {{(ACC_W-ARG_W){arg_sel_s[ARG_W-1]}}, arg_sel_s};
    err_x_s    = {{(ACC_W-WGT_W){err_sel_s[WGT_W-1]}}, err_sel_s};
    wgt_x_s    = {{(ACC_W-WGT_W){rd_data_s[WGT_W-1]}}, rd_data_s};
    // Bias is Q8.8; shifting by 7 aligns it with the Q9.15 arg*w products
    fwd_term_s = is_bias_s ? (wgt_x_s <<< ARG_FRAC) : (arg_x_s * wgt_x_s);
    sum_s      = acc_q + fwd_term_s;
    fbk_term_s = (err_x_s * wgt_x_s) >>> FRAC;
    fbk_sum_s  = $signed(fbk_q[ACC_W*k_arg_s +: ACC_W]) + fbk_term_s;
    upd_s      = is_bias_s ? (err_x_s >>> RATE)
                           : (((err_x_s * arg_x_s) >>> ARG_FRAC) >>> RATE);
    wr_data_s  = sat16(wgt_x_s + upd_s);
    we_s       = (state_q == ST_BWD);
    addr_nx_s  = addr_q + AW'(1);
    if (addr_q == ADDR_LAST) begin
      k_nx_s = '0;
      j_nx_s = '0;
    end else if (is_bias_s) begin
      k_nx_s = '0;
      j_nx_s = j_q + JW'(1);
    end else begin
      k_nx_s = k_q + KW'(1);
      j_nx_s = j_q;
    end
  end

  // Datapath registers: operand latches, accumulators, results, indices
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q <= '0;
      k_q    <= '0;
      j_q    <= '0;
      arg_q  <= '0;
      err_q  <= '0;
      acc_q  <= '0;
      fbk_q  <= '0;
      res_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.arg_stb) begin
            arg_q  <= bus.arg_dat;
            acc_q  <= '0;
            fbk_q  <= '0;
            addr_q <= '0;
            k_q    <= '0;
            j_q    <= '0;
          end
        end
        ST_FWD: begin
          if (addr_q != ADDR_END) begin
            if (is_bias_s) begin
              res_q[ARG_W*j_q +: ARG_W] <= (sum_s >= 32'sd0) ? HEAVI_HI : HEAVI_LO;
              acc_q <= '0;
            end else begin
              acc_q <= sum_s;
            end
            addr_q <= addr_nx_s;
            k_q    <= k_nx_s;
            j_q    <= j_nx_s;
          end
        end
        ST_RES: begin
          if (bus.res_rdy) begin
            addr_q <= '0;
            k_q    <= '0;
            j_q    <= '0;
          end
        end
        ST_ERR: begin
          if (bus.err_stb) begin
            err_q <= bus.err_dat;
          end
        end
        ST_BWD: begin
          if (!is_bias_s) begin
            fbk_q[ACC_W*k_arg_s +: ACC_W] <= fbk_sum_s;
          end
          addr_q <= addr_nx_s;
          k_q    <= k_nx_s;
          j_q    <= j_nx_s;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.arg_rdy = (state_q == ST_IDLE);
  assign bus.res_stb = (state_q == ST_RES);
  assign bus.err_rdy = (state_q == ST_ERR);
  assign bus.fbk_stb = (state_q == ST_FBK);
  assign bus.res_dat = res_q;

  for (genvar i = 0; i < ARGD; i++) begin : g_fbk
    assign bus.fbk_dat[WGT_W*i +: WGT_W] = sat16($signed(fbk_q[ACC_W*i +: ACC_W]));
  end

endmodule

// File: tb/tb_perceptron_layer.sv
// Directed bench: dut_a (RATE=1) covers forward, learning, feedback, backpressure
// and inference; dut_b (RATE=0) shares the stimulus and covers saturation and reset.
module tb_perceptron_layer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, arg_stb, res_rdy, err_stb, fbk_rdy;
  logic [15:0] arg_dat;
  logic [31:0] err_dat;
  int errors = 0;
  int checks = 0;
  int lat;

  perceptron_layer_if #(.ARGD(2), .OUTD(2)) ifa ();
  perceptron_layer_if #(.ARGD(2), .OUTD(2)) ifb ();

  assign ifa.en = en;           assign ifb.en = en;
  assign ifa.arg_stb = arg_stb; assign ifb.arg_stb = arg_stb;
  assign ifa.arg_dat = arg_dat; assign ifb.arg_dat = arg_dat;
  assign ifa.res_rdy = res_rdy; assign ifb.res_rdy = res_rdy;
  assign ifa.err_stb = err_stb; assign ifb.err_stb = err_stb;
  assign ifa.err_dat = err_dat; assign ifb.err_dat = err_dat;
  assign ifa.fbk_rdy = fbk_rdy; assign ifb.fbk_rdy = fbk_rdy;

  perceptron_layer #(.ARGD(2), .OUTD(2), .RATE(1)) dut_a (
    .clk_i (clk), .rst_i (rst), .bus (ifa.slave)
  );
  perceptron_layer #(.ARGD(2), .OUTD(2), .RATE(0)) dut_b (
    .clk_i (clk), .rst_i (rst), .bus (ifb.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_arg(input logic [15:0] d);
    arg_dat = d;
    arg_stb = 1'b1;
    chk("arg_rdy_at_send", {31'd0, ifa.arg_rdy}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    arg_stb = 1'b0;
  endtask

  task automatic wait_res(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ifa.res_stb && n < 40);
  endtask

  task automatic wait_fbk(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ifa.fbk_stb && n < 40);
  endtask

  task automatic take_res(input logic e);
    en = e;
    res_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_rdy = 1'b0;
    en = 1'b0;
  endtask

  task automatic send_err(input logic [31:0] d);
    err_dat = d;
    err_stb = 1'b1;
    chk("err_rdy_at_send", {31'd0, ifa.err_rdy}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    err_stb = 1'b0;
  endtask

  task automatic take_fbk();
    fbk_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fbk_rdy = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; arg_stb = 1'b0; res_rdy = 1'b0;
    err_stb = 1'b0; fbk_rdy = 1'b0; arg_dat = 16'h0000; err_dat = 32'h0000_0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_arg_rdy", {31'd0, ifa.arg_rdy}, 32'd1);
    chk("rst_res_stb", {31'd0, ifa.res_stb}, 32'd0);
    chk("rst_err_rdy", {31'd0, ifa.err_rdy}, 32'd0);
    chk("rst_fbk_stb", {31'd0, ifa.fbk_stb}, 32'd0);
    chk("rst_res_dat", {16'd0, ifa.res_dat}, 32'h0000_0000);
    chk("rst_fbk_dat", ifa.fbk_dat, 32'h0000_0000);
    rst = 1'b0;

    // Forward from reset: all sums zero
    send_arg(16'h4040);
    wait_res(lat);
    chk("fwd_latency", lat, 32'd7);
    chk("fwd_res_dat", {16'd0, ifa.res_dat}, 32'h0000_FFFF);
    take_res(1'b0);
    chk("fwd_idle_arg_rdy", {31'd0, ifa.arg_rdy}, 32'd1);
    chk("fwd_idle_err_rdy", {31'd0, ifa.err_rdy}, 32'd0);

    // First learn step
    send_arg(16'h0040);
    wait_res(lat);
    chk("learn1_res_dat", {16'd0, ifa.res_dat}, 32'h0000_FFFF);
    take_res(1'b1);
    chk("learn1_err_rdy", {31'd0, ifa.err_rdy}, 32'd1);
    chk("learn1_arg_rdy", {31'd0, ifa.arg_rdy}, 32'd0);
    send_err(32'h0000_FF00);
    wait_fbk(lat);
    chk("bwd_latency", lat, 32'd6);
    chk("learn1_fbk_dat", ifa.fbk_dat, 32'h0000_0000);
    take_fbk();
    chk("learn1_idle", {31'd0, ifa.arg_rdy}, 32'd1);
    chk("learn1_w00", {16'd0, dut_a.u_wgt.mem_q[0]}, 32'h0000_FFC0);
    chk("learn1_w01", {16'd0, dut_a.u_wgt.mem_q[1]}, 32'h0000_0000);
    chk("learn1_b0",  {16'd0, dut_a.u_wgt.mem_q[2]}, 32'h0000_FF80);
    chk("learn1_b1",  {16'd0, dut_a.u_wgt.mem_q[5]}, 32'h0000_0000);

    // Forward with learned neuron 0
    send_arg(16'h0040);
    wait_res(lat);
    chk("fwd2_res_dat", {16'd0, ifa.res_dat}, 32'h0000_FF00);
    take_res(1'b0);

    // Second learn step with backpressure on both output channels
    send_arg(16'h0040);
    wait_res(lat);
    chk("bp_res_seen", {31'd0, ifa.res_stb}, 32'd1);
    arg_stb = 1'b1; arg_dat = 16'h1234; err_stb = 1'b1; err_dat = 32'h0100_0100;
    for (int c = 0; c < 5; c++) begin
      chk("bp_res_stb", {31'd0, ifa.res_stb}, 32'd1);
      chk("bp_res_dat", {16'd0, ifa.res_dat}, 32'h0000_FF00);
      chk("bp_res_arg_rdy", {31'd0, ifa.arg_rdy}, 32'd0);
      chk("bp_res_err_rdy", {31'd0, ifa.err_rdy}, 32'd0);
      @(negedge clk);
    end
    arg_stb = 1'b0; err_stb = 1'b0;
    take_res(1'b1);
    send_err(32'h0000_FF00);
    wait_fbk(lat);
    chk("bp_fbk_seen", {31'd0, ifa.fbk_stb}, 32'd1);
    arg_stb = 1'b1; arg_dat = 16'h1234; err_stb = 1'b1; err_dat = 32'h0100_0100;
    for (int c = 0; c < 5; c++) begin
      chk("bp_fbk_stb", {31'd0, ifa.fbk_stb}, 32'd1);
      chk("bp_fbk_dat", ifa.fbk_dat, 32'h0000_0040);
      chk("bp_fbk_arg_rdy", {31'd0, ifa.arg_rdy}, 32'd0);
      chk("bp_fbk_err_rdy", {31'd0, ifa.err_rdy}, 32'd0);
      @(negedge clk);
    end
    arg_stb = 1'b0; err_stb = 1'b0;
    take_fbk();
    chk("learn2_idle", {31'd0, ifa.arg_rdy}, 32'd1);
    chk("learn2_w00", {16'd0, dut_a.u_wgt.mem_q[0]}, 32'h0000_FF80);
    chk("learn2_b0",  {16'd0, dut_a.u_wgt.mem_q[2]}, 32'h0000_FF00);

    // Inference only: stray error strobes must be ignored
    err_stb = 1'b1; err_dat = 32'h0100_0100;
    send_arg(16'h0040);
    wait_res(lat);
    chk("inf1_res_dat", {16'd0, ifa.res_dat}, 32'h0000_FF00);
    take_res(1'b0);
    chk("inf1_arg_rdy", {31'd0, ifa.arg_rdy}, 32'd1);
    chk("inf1_err_rdy", {31'd0, ifa.err_rdy}, 32'd0);
    send_arg(16'h7F7F);
    wait_res(lat);
    chk("inf2_res_dat", {16'd0, ifa.res_dat}, 32'h0000_FF00);
    take_res(1'b0);
    chk("inf2_err_rdy", {31'd0, ifa.err_rdy}, 32'd0);
    send_arg(16'h8080);
    wait_res(lat);
    chk("inf3_res_dat", {16'd0, ifa.res_dat}, 32'h0000_FF00);
    take_res(1'b0);
    chk("inf3_err_rdy", {31'd0, ifa.err_rdy}, 32'd0);
    err_stb = 1'b0;
    chk("inf_w00", {16'd0, dut_a.u_wgt.mem_q[0]}, 32'h0000_FF80);
    chk("inf_b0",  {16'd0, dut_a.u_wgt.mem_q[2]}, 32'h0000_FF00);

    // Saturation on dut_b (RATE=0) from a clean reset
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    send_arg(16'h7F7F);
    wait_res(lat);
    take_res(1'b1);
    send_err(32'h7FFF_7FFF);
    wait_fbk(lat);
    chk("sat1_fbk_dat", ifb.fbk_dat, 32'h0000_0000);
    take_fbk();
    chk("sat1_w00", {16'd0, dut_b.u_wgt.mem_q[0]}, 32'h0000_7EFF);
    chk("sat1_b0",  {16'd0, dut_b.u_wgt.mem_q[2]}, 32'h0000_7FFF);
    send_arg(16'h7F7F);
    wait_res(lat);
    take_res(1'b1);
    send_err(32'h7FFF_7FFF);
    wait_fbk(lat);
    chk("sat2_fbk_dat", ifb.fbk_dat, 32'h7FFF_7FFF);
    take_fbk();
    chk("sat2_w00", {16'd0, dut_b.u_wgt.mem_q[0]}, 32'h0000_7FFF);
    chk("sat2_w01", {16'd0, dut_b.u_wgt.mem_q[1]}, 32'h0000_7FFF);
    chk("sat2_w11", {16'd0, dut_b.u_wgt.mem_q[4]}, 32'h0000_7FFF);
    chk("sat2_b1",  {16'd0, dut_b.u_wgt.mem_q[5]}, 32'h0000_7FFF);

    // Reset in the middle of a forward pass
    send_arg(16'h7F7F);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rstfwd_res_stb", {31'd0, ifb.res_stb}, 32'd0);
    chk("rstfwd_arg_rdy", {31'd0, ifb.arg_rdy}, 32'd1);
    chk("rstfwd_w00", {16'd0, dut_b.u_wgt.mem_q[0]}, 32'h0000_0000);
    chk("rstfwd_b1",  {16'd0, dut_b.u_wgt.mem_q[5]}, 32'h0000_0000);
    rst = 1'b0;
    send_arg(16'h7F7F);
    wait_res(lat);
    chk("rstfwd_latency", lat, 32'd7);
    chk("rstfwd_res_dat", {16'd0, ifb.res_dat}, 32'h0000_FFFF);
    take_res(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
